axi_sft_tmr_decerr_rd_resp: RTL

- Triplicated (TMR) read decode-error responder: the responder for the read-command output of the crossbar address stage.
- Consumes read commands flagged as decode errors and returns a DECERR read burst of the requested length on an AXI R channel.
- After the last beat it returns a completion (id, valid) to the address stage so that stage can retire the transaction.
- All control state is held in three copies, majority-voted every cycle and scrubbed; a mismatch flag is exported.

---
 rtl/axi_sft_tmr_decerr_rd_resp.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/axi_sft_tmr_decerr_rd_resp.sv
`default_nettype none
// ============================================================================
// Module   : axi_sft_tmr_decerr_rd_resp
// Brief    : Triplicated read decode-error responder. Accepts read commands
//            flagged as DECERR, returns a DECERR R burst of arlen+1 beats and
//            then strobes a completion back to the address stage. All control
//            state is held in three voted, self-scrubbing copies.
// Revision : 1.0 - initial release
// ============================================================================
module axi_sft_tmr_decerr_rd_resp #(
    parameter int ID_WIDTH   = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_rc_id,
    input  logic [7:0]            s_rc_len,
    input  logic                  s_rc_decerr,
    input  logic                  s_rc_valid,
    output logic                  s_rc_ready,
    output logic [ID_WIDTH-1:0]   m_axi_rid,
    output logic [DATA_WIDTH-1:0] m_axi_rdata,
    output logic [1:0]            m_axi_rresp,
    output logic                  m_axi_rlast,
    output logic                  m_axi_rvalid,
    input  logic                  m_axi_rready,
    output logic [ID_WIDTH-1:0]   m_cpl_id,
    output logic                  m_cpl_valid,
    input  logic [2:0]            tmr_inject,
    output logic                  tmr_err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    // Three copies of every control register
    state_t              r_state  [3];
    logic [7:0]          r_cnt    [3];
    logic [ID_WIDTH-1:0] r_id     [3];
    logic                r_cpl_v  [3];
    logic [ID_WIDTH-1:0] r_cpl_id [3];
    logic                r_tmr_err;

    // Voted views of the copies
    state_t              w_state;
    logic [7:0]          w_cnt;
    logic [ID_WIDTH-1:0] w_id;
    logic                w_cpl_v;
    logic [ID_WIDTH-1:0] w_cpl_id;
    logic                w_mismatch;

    // Next values, computed from voted state only and loaded into all copies
    state_t              w_nxt_state;
    logic [7:0]          w_nxt_cnt;
    logic [ID_WIDTH-1:0] w_nxt_id;
    logic                w_nxt_cpl_v;
    logic [ID_WIDTH-1:0] w_nxt_cpl_id;
    logic                w_cmd_hs;

    // Bitwise majority vote of each field and detection of any disagreeing copy
    always_comb begin
        w_state  = state_t'((r_state[0] & r_state[1]) | (r_state[0] & r_state[2]) |
                            (r_state[1] & r_state[2]));
        w_cnt    = (r_cnt[0] & r_cnt[1]) | (r_cnt[0] & r_cnt[2]) | (r_cnt[1] & r_cnt[2]);
        w_id     = (r_id[0] & r_id[1]) | (r_id[0] & r_id[2]) | (r_id[1] & r_id[2]);
        w_cpl_v  = (r_cpl_v[0] & r_cpl_v[1]) | (r_cpl_v[0] & r_cpl_v[2]) |
                   (r_cpl_v[1] & r_cpl_v[2]);
        w_cpl_id = (r_cpl_id[0] & r_cpl_id[1]) | (r_cpl_id[0] & r_cpl_id[2]) |
                   (r_cpl_id[1] & r_cpl_id[2]);
        w_mismatch = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if ((r_state[k] != w_state) || (r_cnt[k] != w_cnt) || (r_id[k] != w_id) ||
                (r_cpl_v[k] != w_cpl_v) || (r_cpl_id[k] != w_cpl_id)) begin
                w_mismatch = 1'b1;
            end
        end
    end

    assign s_rc_ready   = (w_state == S_IDLE) & ~rst;
    assign m_axi_rvalid = (w_state == S_RESP);
    assign m_axi_rid    = w_id;
    assign m_axi_rdata  = '0;
    assign m_axi_rresp  = c_RESP_DECERR;
    assign m_axi_rlast  = (w_state == S_RESP) && (w_cnt == 8'd0);
    assign m_cpl_valid  = w_cpl_v;
    assign m_cpl_id     = w_cpl_id;
    assign tmr_err      = r_tmr_err;
    assign w_cmd_hs     = s_rc_valid & s_rc_ready;

    // Responder control: capture DECERR commands, count beats, retire on last
    always_comb begin
        w_nxt_state  = w_state;
        w_nxt_cnt    = w_cnt;
        w_nxt_id     = w_id;
        w_nxt_cpl_v  = 1'b0;
        w_nxt_cpl_id = w_cpl_id;
        case (w_state)
            S_IDLE: begin
                // Non-DECERR commands are consumed silently
                if (w_cmd_hs && s_rc_decerr) begin
                    w_nxt_id    = s_rc_id;
                    w_nxt_cnt   = s_rc_len;
                    w_nxt_state = S_RESP;
                end
            end
            S_RESP: begin
                if (m_axi_rready) begin
                    if (w_cnt != 8'd0) begin
                        w_nxt_cnt = w_cnt - 8'd1;
                    end else begin
                        w_nxt_state  = S_IDLE;
                        w_nxt_cpl_v  = 1'b1;
                        w_nxt_cpl_id = w_id;
                    end
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // Each copy reloads the voted next value; injection flips one copy's state bit
    for (genvar k = 0; k < 3; k++) begin : g_copy
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state[k]  <= S_IDLE;
                r_cnt[k]    <= 8'd0;
                r_id[k]     <= '0;
                r_cpl_v[k]  <= 1'b0;
                r_cpl_id[k] <= '0;
            end else begin
                r_state[k]  <= state_t'(w_nxt_state ^ tmr_inject[k]);
                r_cnt[k]    <= w_nxt_cnt;
                r_id[k]     <= w_nxt_id;
                r_cpl_v[k]  <= w_nxt_cpl_v;
                r_cpl_id[k] <= w_nxt_cpl_id;
            end
        end
    end

    // One-cycle error pulse following any cycle with a disagreeing copy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmr_err <= 1'b0;
        end else begin
            r_tmr_err <= w_mismatch;
        end
    end

endmodule
`default_nettype wire
